inversion_arbiter: RTL and testbench
====================================

# inversion_arbiter

Round-robin scheduler that shares one Montgomery-domain modular inverter among `NUM_REQ` requesters, such as the pairing Fp/Fp2 units. It accepts one operand at a time through a valid/ready handshake and drives the inverter's `start`/`a` inputs. It captures `c` on `comp` and returns the result tagged with the requester index. The inverter takes a data-dependent number of cycles, so at most one inversion is in flight.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be 2..16.
- `ID_W`, default 2: requester-index width; must satisfy 2^`ID_W` ≥ `NUM_REQ`.
- `WORD_SIZE`: operand width, taken from the shared parameter header, not overridable.

- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input `NUM_REQ`: per-requester operand valid.
- `req_data` input `NUM_REQ*WORD_SIZE`: packed operands, requester i at bits [i*WORD_SIZE +: WORD_SIZE], in Montgomery form.
- `req_ready` output `NUM_REQ`: one-hot grant, at most one bit high.
- `resp_valid` output 1: result available.
- `resp_id` output `ID_W`: index of the requester that owns the result.
- `resp_data` output `WORD_SIZE`: Montgomery form of the modular inverse.
- `resp_err` output 1: zero operand was rejected (requires `INV_ZERO_CHECK_EN`).
- `resp_ready` input 1: consumer accepts the response.
- `inv_start` output 1: one-cycle start pulse to the inverter.
- `inv_a` output `WORD_SIZE`: operand to the inverter, registered.
- `inv_c` input `WORD_SIZE`: inverter result, valid while `inv_comp` is high.
- `inv_comp` input 1: inverter one-cycle completion pulse.
- `busy` output 1: state is not IDLE.

## Operation
- The FSM has four states:
  - IDLE: grant is possible.
  - START: `inv_start` is high.
  - WAIT: waiting for `inv_comp`.
  - RESP: `resp_valid` is high.
- IDLE:
  - `req_ready` is combinational. Only the round-robin winner among `req_valid` bits is high.
  - The search starts at (last_grant+1) mod `NUM_REQ`.
  - On a handshake, latch the operand into `inv_a` and the index into the ID register, update last_grant, and go to START.
- START: drive `inv_start`=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold `inv_a`.
  - On `inv_comp`=1, register `inv_c` into `resp_data`, clear `resp_err`, and go to RESP.
- RESP:
  - `resp_valid`=1. `resp_id`, `resp_data` and `resp_err` stay stable until `resp_ready`=1.
  - On that cycle go to IDLE. No grant is issued in the same cycle.
- `inv_comp` seen outside WAIT is ignored.
- Withdrawing `req_valid` before a grant is legal. The pointer is unaffected.
- No arbitration happens outside IDLE. Pending requests simply wait, and `req_ready` is all-zero.

## Timing
- Reset values: every output is 0, state is IDLE, last_grant is `NUM_REQ`-1 (so requester 0 wins first), `inv_a`=0.
- Reset mid-operation returns to IDLE immediately and drops any in-flight result. The inverter shares `rst_n`, so it is reset too.
- Handshake in cycle T: `inv_start` is high in T+1.
- `inv_comp` in cycle C: `resp_valid` rises in C+1.
- `resp_ready` in cycle R: IDLE in R+1, with the next grant possible in R+1.
- Back-to-back minimum is 3 arbiter-overhead cycles plus the inverter latency.

## Configuration
- `INV_ZERO_CHECK_EN` defined:
  - In IDLE, a granted operand equal to 0 skips START/WAIT and goes directly to RESP in T+1.
  - The response is `resp_data`=0 and `resp_err`=1. `inv_start` is never pulsed.
- Undefined:
  - Zero is forwarded to the inverter like any other operand, and `resp_err` is tied to 0.
  - A zero operand may then never complete. Callers guarantee nonzero operands.

## Structure
- Shared parameter header holds `WORD_SIZE` and the state encodings `INV_ARB_IDLE`/`START`/`WAIT`/`RESP` (2-bit).
- Sub-module `rr_arbiter` is parameterised by `NUM_REQ`:
  - Inputs: request vector and last_grant.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.

## Test plan
- Single request: requester 2 sends operand Mont(3), inverter model with 40-cycle latency -> `inv_start` at T+1, `resp_valid` at comp+1 with `resp_id`=2 and `resp_data`=Mont(3⁻¹ mod p).
- Fairness: all four `req_valid` held high for 8 inversions -> grant order 0,1,2,3,0,1,2,3.
- Backpressure: `resp_ready` held low 10 cycles -> `resp_*` stable throughout, no new `req_ready`, single IDLE transition after release.
- Spurious comp: `inv_comp` pulse in IDLE and in START -> ignored, no response generated.
- Reset mid-WAIT: `rst_n` low for 1 cycle -> all outputs 0, next grant goes to requester 0.
- Zero operand with `INV_ZERO_CHECK_EN`: `req_data`=0 -> no `inv_start`, `resp_valid` at T+1, `resp_err`=1, `resp_data`=0.

Source files
------------

// File: rtl/inversion_arbiter_pkg.sv
// rtl/inversion_arbiter_pkg.sv - shared operand width and arbiter state encodings
package inversion_arbiter_pkg;

    localparam int WORD_SIZE = 32;

    typedef enum logic [1:0] {
        INV_ARB_IDLE  = 2'd0,
        INV_ARB_START = 2'd1,
        INV_ARB_WAIT  = 2'd2,
        INV_ARB_RESP  = 2'd3
    } inv_arb_state_e;

endpackage

// File: rtl/inversion_arbiter_rr_arbiter.sv
// rtl/inversion_arbiter_rr_arbiter.sv - combinational round-robin picker, search starts after last_i
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(last_i) + k) % NUM_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/inversion_arbiter.sv
// rtl/inversion_arbiter.sv - round-robin front end for a shared modular inverter, one inversion in flight
// Optional zero-operand rejection: define INV_ZERO_CHECK_EN.
module inversion_arbiter
    import inversion_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WORD_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         resp_valid,
    output logic [ID_W-1:0]              resp_id,
    output logic [WORD_SIZE-1:0]         resp_data,
    output logic                         resp_err,
    input  logic                         resp_ready,
    output logic                         inv_start,
    output logic [WORD_SIZE-1:0]         inv_a,
    input  logic [WORD_SIZE-1:0]         inv_c,
    input  logic                         inv_comp,
    output logic                         busy
);

    inv_arb_state_e       state_q;
    logic [ID_W-1:0]      last_q;
    logic [ID_W-1:0]      id_q;
    logic [WORD_SIZE-1:0] inv_a_q;
    logic [WORD_SIZE-1:0] resp_data_q;
    logic                 inv_start_q;
    logic                 resp_valid_q;

    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_idx;
    logic [WORD_SIZE-1:0] sel_data;
    logic                 handshake;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    assign req_ready = (state_q == INV_ARB_IDLE) ? gnt : '0;
    assign handshake = |(req_valid & req_ready);
    assign sel_data  = req_data[gnt_idx*WORD_SIZE +: WORD_SIZE];

`ifdef INV_ZERO_CHECK_EN
    logic resp_err_q;
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INV_ARB_IDLE;
            last_q       <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            inv_a_q      <= '0;
            resp_data_q  <= '0;
            inv_start_q  <= 1'b0;
            resp_valid_q <= 1'b0;
`ifdef INV_ZERO_CHECK_EN
            resp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                INV_ARB_IDLE: begin
                    if (handshake) begin
                        id_q    <= gnt_idx;
                        last_q  <= gnt_idx;
                        inv_a_q <= sel_data;
`ifdef INV_ZERO_CHECK_EN
                        // Zero has no inverse; answer immediately without touching the inverter.
                        if (sel_data == '0) begin
                            state_q      <= INV_ARB_RESP;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= '0;
                            resp_err_q   <= 1'b1;
                        end else
`endif
                        begin
                            inv_start_q <= 1'b1;
                            state_q     <= INV_ARB_START;
                        end
                    end
                end
                INV_ARB_START: begin
                    inv_start_q <= 1'b0;
                    state_q     <= INV_ARB_WAIT;
                end
                INV_ARB_WAIT: begin
                    if (inv_comp) begin
                        resp_data_q  <= inv_c;
                        resp_valid_q <= 1'b1;
`ifdef INV_ZERO_CHECK_EN
                        resp_err_q   <= 1'b0;
`endif
                        state_q      <= INV_ARB_RESP;
                    end
                end
                INV_ARB_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= INV_ARB_IDLE;
                    end
                end
                default: state_q <= INV_ARB_IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_valid_q ? id_q : '0;
    assign resp_data  = resp_data_q;
    assign inv_start  = inv_start_q;
    assign inv_a      = inv_a_q;
    assign busy       = (state_q != INV_ARB_IDLE);

endmodule

// File: tb/tb_inversion_arbiter.sv
// tb/tb_inversion_arbiter.sv - directed bench for inversion_arbiter with a behavioural inverter
module tb_inversion_arbiter;
    import inversion_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int WS = WORD_SIZE;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*WS-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              resp_valid;
    logic [IW-1:0]     resp_id;
    logic [WS-1:0]     resp_data;
    logic              resp_err;
    logic              resp_ready = 1'b0;
    logic              inv_start;
    logic [WS-1:0]     inv_a;
    logic [WS-1:0]     inv_c = '0;
    logic              inv_comp;
    logic              busy;

    logic              model_comp = 1'b0;
    logic              spur_comp = 1'b0;
    int                model_lat = 40;
    int                model_cnt = 0;
    int                start_count = 0;
    logic [WS-1:0]     model_a = '0;
    int                n_chk = 0;
    int                n_pass = 0;

    assign inv_comp = model_comp | spur_comp;

    inversion_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .resp_ready (resp_ready),
        .inv_start  (inv_start),
        .inv_a      (inv_a),
        .inv_c      (inv_c),
        .inv_comp   (inv_comp),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // p = 97, R = 2^32 mod 97 = 35: Mont(3) = 8, Mont(3^-1) = Mont(65) = 44.
    function automatic logic [WS-1:0] inv_fn(input logic [WS-1:0] a);
        return (a == 32'd8) ? 32'd44 : ~a;
    endfunction

    always @(negedge clk) begin
        model_comp = 1'b0;
        if (!rst_n) begin
            model_cnt = 0;
        end else begin
            if (model_cnt > 0) begin
                model_cnt = model_cnt - 1;
                if (model_cnt == 0) begin
                    model_comp = 1'b1;
                    inv_c      = inv_fn(model_a);
                end
            end
            if (inv_start) begin
                model_cnt   = model_lat;
                model_a     = inv_a;
                start_count = start_count + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [WS-1:0] v);
        req_data[i*WS +: WS] = v;
    endtask

    task automatic wait_resp(input string tag, input int budget);
        int t;
        t = 0;
        while (!resp_valid && t < budget) begin
            step();
            t++;
        end
        check(tag, {63'd0, resp_valid}, 64'd1);
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        int lat_seen;
        int t;
        int starts0;

        // Reset state
        step();
        check("rst_outputs", {busy, inv_start, resp_valid, resp_err, req_ready, resp_id},
              {54'd0, 10'd0});
        check("rst_inv_a", {32'd0, inv_a}, 64'd0);
        check("rst_resp_data", {32'd0, resp_data}, 64'd0);
        rst_n = 1'b1;
        step();

        // Single request from requester 2, 40-cycle inverter
        model_lat = 40;
        set_data(2, 32'd8);
        req_valid = 4'b0100;
        #1;
        check("single_ready", {60'd0, req_ready}, 64'h4);
        step();
        req_valid = '0;
        check("single_start", {63'd0, inv_start}, 64'd1);
        check("single_inv_a", {32'd0, inv_a}, 64'd8);
        check("single_busy_noready", {59'd0, busy, req_ready}, {59'd0, 5'b10000});
        lat_seen = 0;
        while (!inv_comp && lat_seen < 100) begin
            step();
            lat_seen++;
        end
        check("single_latency", 64'(lat_seen), 64'd40);
        check("single_pre_resp", {63'd0, resp_valid}, 64'd0);
        step();
        check("single_resp", {resp_valid, resp_err, resp_id, resp_data},
              {28'd0, 1'b1, 1'b0, 2'd2, 32'd44});
        release_resp();
        check("single_idle", {62'd0, busy, resp_valid}, 64'd0);

        // Backpressure: requester 1 served, requester 3 pending while response is held
        model_lat = 4;
        set_data(1, 32'd5);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1000;
        set_data(3, 32'd11);
        wait_resp("bp_resp_seen", 50);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {resp_valid, resp_id, resp_data, req_ready},
                  {25'd0, 1'b1, 2'd1, ~32'd5, 4'b0000});
            step();
        end
        release_resp();
        check("bp_released", {resp_valid, busy, req_ready}, {58'd0, 2'b00, 4'b1000});
        req_valid = '0;
        step();
        check("bp_withdraw_idle", {62'd0, busy, inv_start}, 64'd0);

        // Spurious comp in IDLE, then in START
        spur_comp = 1'b1;
        step();
        spur_comp = 1'b0;
        check("spur_idle", {62'd0, resp_valid, busy}, 64'd0);
        set_data(0, 32'd7);
        req_valid = 4'b0001;
        #1;
        check("spur_grant0", {60'd0, req_ready}, 64'h1);
        step();
        req_valid = '0;
        check("spur_in_start", {63'd0, inv_start}, 64'd1);
        spur_comp = 1'b1;
        step();
        spur_comp = 1'b0;
        check("spur_start_ignored", {61'd0, resp_valid, busy, inv_start}, {61'd0, 3'b010});
        wait_resp("spur_resp_seen", 50);
        check("spur_resp", {resp_id, resp_data}, {30'd0, 2'd0, ~32'd7});
        release_resp();

        // Reset mid-WAIT
        model_lat = 40;
        set_data(1, 32'd9);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        step();
        check("pre_reset_wait", {62'd0, busy, resp_valid}, 64'd2);
        rst_n = 1'b0;
        #1;
        check("reset_mid_wait", {busy, inv_start, resp_valid, resp_err, req_ready, resp_id, inv_a},
              {22'd0, 10'd0, 32'd0});
        step();
        rst_n = 1'b1;
        step();

        // Fairness: all four request continuously
        model_lat = 3;
        for (int i = 0; i < NR; i++) set_data(i, 32'(100 + i));
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            t = 0;
            while (req_ready == '0 && t < 50) begin
                step();
                t++;
            end
            check("fair_grant", {60'd0, req_ready}, 64'(1 << (k % 4)));
            step();
            wait_resp("fair_resp_seen", 50);
            check("fair_resp", {resp_id, resp_data}, {30'd0, 2'(k % 4), ~32'(100 + (k % 4))});
            release_resp();
            if (k == 7) req_valid = '0;
        end

`ifdef INV_ZERO_CHECK_EN
        // Zero operand rejected without an inverter start
        step();
        starts0 = start_count;
        set_data(0, 32'd0);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        check("zero_resp", {inv_start, resp_valid, resp_err, resp_id, resp_data},
              {27'd0, 1'b0, 1'b1, 1'b1, 2'd0, 32'd0});
        step();
        check("zero_no_start", 64'(start_count - starts0), 64'd0);
        release_resp();
        check("zero_idle", {62'd0, busy, resp_valid}, 64'd0);
`else
        starts0 = start_count;
        check("start_total", 64'(starts0), 64'd12);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
